// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder/subtractor.
// This package holds the state encoding, the digit geometry and a digit validity helper.
package bcd_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic isBadDigit(input logic [DIGIT_W-1:0] d);
      return d > MAX_DIGIT;
   endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One-digit decimal adder with an optional nine's-complement on b_i.
// The sequencer uses it for both the main pass and the ten's-complement fix-up pass.
module bcd_digit_addsub
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a_i,
   input  logic [DIGIT_W-1:0] b_i,
   input  logic               cin,
   input  logic               sub,
   output logic [DIGIT_W-1:0] r_i,
   output logic               cout
);

   logic [DIGIT_W-1:0] bd;
   logic [DIGIT_W:0]   sum;

   // A binary sum above 9 wraps back into 0..9 and produces a decimal carry.
   always_comb begin
      bd   = sub ? (MAX_DIGIT - b_i) : b_i;
      sum  = {1'b0, a_i} + {1'b0, bd} + {{DIGIT_W{1'b0}}, cin};
      r_i  = sum[DIGIT_W-1:0];
      cout = 1'b0;
      if (sum > {1'b0, MAX_DIGIT}) begin
         r_i  = DIGIT_W'(sum - (DIGIT_W+1)'(10));
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor that processes one digit per clock, LSD first.
// A negative difference is turned into its magnitude by a second ten's-complement pass.
module bcd_addsub_serial
   import bcd_pkg::*;
#(
   parameter int NDIGITS = 4
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       mode,
   input  logic [DIGIT_W*NDIGITS-1:0] a,
   input  logic [DIGIT_W*NDIGITS-1:0] b,
   output logic                       busy,
   output logic                       done,
   output logic [DIGIT_W*NDIGITS-1:0] result,
   output logic                       cout,
   output logic                       neg,
   output logic                       err
);

   localparam int W     = DIGIT_W * NDIGITS;
   localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

   state_t             state_q,  state_d;
   logic [W-1:0]       a_q,      a_d;
   logic [W-1:0]       b_q,      b_d;
   logic               mode_q,   mode_d;
   logic [W-1:0]       result_q, result_d;
   logic               cout_q,   cout_d;
   logic               neg_q,    neg_d;
   logic               err_q,    err_d;
   logic [IDX_W-1:0]   idx_q,    idx_d;
   logic               carry_q,  carry_d;

   logic [DIGIT_W-1:0] digA, digB, digR;
   logic               digSub, digCout;
   logic               badOperand;

   always_comb begin
      badOperand = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (isBadDigit(a[i*DIGIT_W +: DIGIT_W]) || isBadDigit(b[i*DIGIT_W +: DIGIT_W])) begin
            badOperand = 1'b1;
         end
      end
   end

   // In FIX the current result digit r is fed as b with a=0, so the cell yields 9-r+carry.
   always_comb begin
      digA   = a_q[idx_q*DIGIT_W +: DIGIT_W];
      digB   = b_q[idx_q*DIGIT_W +: DIGIT_W];
      digSub = mode_q;
      if (state_q == FIX) begin
         digA   = '0;
         digB   = result_q[idx_q*DIGIT_W +: DIGIT_W];
         digSub = 1'b1;
      end
   end

   bcd_digit_addsub u_digit (
      .a_i  (digA),
      .b_i  (digB),
      .cin  (carry_q),
      .sub  (digSub),
      .r_i  (digR),
      .cout (digCout)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      mode_d   = mode_q;
      result_d = result_q;
      cout_d   = cout_q;
      neg_d    = neg_q;
      err_d    = err_q;
      idx_d    = idx_q;
      carry_d  = carry_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               mode_d   = mode;
               result_d = '0;
               cout_d   = 1'b0;
               neg_d    = 1'b0;
               err_d    = badOperand;
               idx_d    = '0;
               carry_d  = mode;
               state_d  = badOperand ? DONE : CALC;
            end
         end
         CALC: begin
            result_d[idx_q*DIGIT_W +: DIGIT_W] = digR;
            carry_d = digCout;
            if (idx_q == LAST_IDX) begin
               if (!mode_q) begin
                  cout_d  = digCout;
                  state_d = DONE;
               end else if (digCout) begin
                  state_d = DONE;
               end else begin
                  // No final borrow-carry means a<b: complement the nine's-complement result.
                  neg_d   = 1'b1;
                  idx_d   = '0;
                  carry_d = 1'b1;
                  state_d = FIX;
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         FIX: begin
            result_d[idx_q*DIGIT_W +: DIGIT_W] = digR;
            carry_d = digCout;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mode_q   <= mode_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         neg_q    <= neg_d;
         err_q    <= err_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign cout   = cout_q;
   assign neg    = neg_q;
   assign err    = err_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench for bcd_addsub_serial: an integer reference model queues expectations per operation.
// A negedge monitor pops one entry for each done pulse.
module tb_bcd_addsub_serial;

   localparam int N = 4;
   localparam int W = 4 * N;

   typedef struct {
      logic [W-1:0] result;
      logic         cout;
      logic         neg;
      logic         err;
      int           latency;
      int           acceptCycle;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         mode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         neg;
   logic         err;

   int   checkCount = 0;
   int   passCount  = 0;
   int   cycleCount = 0;
   exp_t sbQueue[$];

   bcd_addsub_serial #(.NDIGITS(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .mode   (mode),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .neg    (neg),
      .err    (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic exp_t model(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      int   ai = 0;
      int   bi = 0;
      int   r  = 0;
      logic bad = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (av[i*4 +: 4] > 4'd9 || bv[i*4 +: 4] > 4'd9) bad = 1'b1;
         ai = ai * 10 + int'(av[i*4 +: 4]);
         bi = bi * 10 + int'(bv[i*4 +: 4]);
      end
      e.cout = 1'b0;
      e.neg  = 1'b0;
      e.err  = bad;
      e.acceptCycle = 0;
      if (bad) begin
         e.latency = 1;
         r = 0;
      end else if (!m) begin
         r = ai + bi;
         e.cout = (r >= 10000);
         r = r % 10000;
         e.latency = N + 1;
      end else begin
         r = ai - bi;
         e.latency = N + 1;
         if (r < 0) begin
            r = -r;
            e.neg = 1'b1;
            e.latency = 2 * N + 1;
         end
      end
      for (int i = 0; i < N; i++) begin
         e.result[i*4 +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return e;
   endfunction

   function automatic logic [W-1:0] randBcd();
      logic [W-1:0] v;
      for (int i = 0; i < N; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   // Every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sbQueue.size() == 0) begin
            checkOutput("unexpectedDone", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sbQueue.pop_front();
            checkOutput("result",  32'(result), 32'(e.result));
            checkOutput("cout",    32'(cout),   32'(e.cout));
            checkOutput("neg",     32'(neg),    32'(e.neg));
            checkOutput("err",     32'(err),    32'(e.err));
            checkOutput("latency", 32'(cycleCount - e.acceptCycle + 1), 32'(e.latency));
         end
      end
   end

   // Called at a negedge with the DUT idle; optionally pulses start again mid-operation.
   task automatic applyStimulus(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv, input bit inject);
      exp_t e;
      bit   seen = 0;
      e = model(m, av, bv);
      e.acceptCycle = cycleCount + 1;
      sbQueue.push_back(e);
      start = 1'b1;
      mode  = m;
      a     = av;
      b     = bv;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1;
         if (k == 0) begin
            start = inject && !seen;
            mode  = ~m;
            a     = inject ? 16'h9999 : 16'hFFFF;
            b     = inject ? 16'h9999 : 16'hFFFF;
         end
         if (k == 1) start = 1'b0;
      end
      start = 1'b0;
      if (!seen) begin
         checkOutput("doneTimeout", 32'd0, 32'd1);
         if (sbQueue.size() > 0) void'(sbQueue.pop_front());
      end else begin
         @(negedge clk);
         checkOutput("holdResult", 32'(result), 32'(e.result));
         checkOutput("holdNeg",    32'(neg),    32'(e.neg));
         checkOutput("holdErr",    32'(err),    32'(e.err));
         checkOutput("idleBusy",   32'(busy),   32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      checkOutput("rstBusy",   32'(busy),   32'd0);
      checkOutput("rstDone",   32'(done),   32'd0);
      checkOutput("rstResult", 32'(result), 32'd0);
      checkOutput("rstCout",   32'(cout),   32'd0);
      checkOutput("rstNeg",    32'(neg),    32'd0);
      checkOutput("rstErr",    32'(err),    32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(1'b0, 16'h0999, 16'h0001, 0);
      applyStimulus(1'b0, 16'h9999, 16'h0001, 0);
      applyStimulus(1'b0, 16'h4567, 16'h5432, 0);
      applyStimulus(1'b1, 16'h0008, 16'h0009, 0);
      applyStimulus(1'b1, 16'h0003, 16'h0002, 0);
      applyStimulus(1'b1, 16'h0005, 16'h0005, 0);
      applyStimulus(1'b1, 16'h0000, 16'h9999, 0);
      applyStimulus(1'b0, 16'h000A, 16'h0008, 0);
      applyStimulus(1'b0, 16'h1234, 16'h4321, 0);
      applyStimulus(1'b1, 16'h2345, 16'h1111, 1);
      applyStimulus(1'b0, 16'h0500, 16'h0700, 1);
      applyStimulus(1'b1, 16'h9B00, 16'h0001, 0);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), randBcd(), randBcd(), 0);
      end

      // Reset in the second CALC cycle must abort silently.
      begin
         exp_t e;
         e = model(1'b0, 16'h1234, 16'h4321);
         e.acceptCycle = cycleCount + 1;
         sbQueue.push_back(e);
         start = 1'b1;
         mode  = 1'b0;
         a     = 16'h1234;
         b     = 16'h4321;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         checkOutput("abortBusy",   32'(busy),   32'd0);
         checkOutput("abortDone",   32'(done),   32'd0);
         checkOutput("abortResult", 32'(result), 32'd0);
         checkOutput("abortCout",   32'(cout),   32'd0);
         checkOutput("abortNeg",    32'(neg),    32'd0);
         checkOutput("abortErr",    32'(err),    32'd0);
         sbQueue.delete();
         rst_n = 1'b1;
         repeat (12) @(negedge clk);
      end

      applyStimulus(1'b1, 16'h0100, 16'h0099, 0);
      checkOutput("queueEmpty", 32'(sbQueue.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
